// File: rtl/lc4_fetch_ctl.sv
// rtl/lc4_fetch_ctl.sv - LC4 fetch/issue/flag controller, one instruction in flight.
// Optional illegal-opcode trap: define ILLEGAL_TRAP_EN.
module lc4_fetch_ctl #(
  parameter int WORD_SIZE = 256,
  parameter int INSN      = 19,
  parameter int IADDR     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [IADDR:0]       o_imem_addr,
  input  logic [INSN:0]        i_imem_data,
  output logic [INSN:0]        o_insn,
  output logic [IADDR:0]       o_pc,
  output logic                 o_carry,
  output logic                 o_insn_valid,
  input  logic                 i_insn_ready,
  input  logic                 i_wb_valid,
  input  logic [WORD_SIZE-1:0] i_wb_result,
  input  logic                 i_wb_carry,
  output logic [2:0]           o_nzp,
  output logic                 o_retire
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                 o_illegal
`endif
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ISSUE,
    S_WAIT_WB
`ifdef ILLEGAL_TRAP_EN
    ,
    S_HALT
`endif
  } state_t;

  localparam logic [IADDR:0] PC_ONE = {{IADDR{1'b0}}, 1'b1};

  state_t          state;
  logic [IADDR:0]  pc;
  logic [4:0]      opcode;
  logic            res_n;
  logic            res_z;
  logic            legal;
  logic            sets_nzp;
  logic            sets_carry;
  logic            redirect;

  function automatic logic is_legal(input logic [4:0] op);
    return (op <= 5'b10101) && (op != 5'b10001);
  endfunction

  // The address register doubles as the PC; imem sees it for the whole FETCH cycle.
  assign o_imem_addr = pc;
  assign opcode      = o_insn[INSN -: 5];
  assign res_n       = i_wb_result[WORD_SIZE-1];
  assign res_z       = (i_wb_result == '0);
  assign legal       = is_legal(opcode);

  // Every legal opcode other than NOP, branches, JSR and RTI writes the flags.
  assign sets_nzp = legal && (opcode > 5'b00100) && (opcode != 5'b01000) && (opcode != 5'b01010);

  assign sets_carry = (opcode == 5'b00101) || (opcode == 5'b00110) || (opcode == 5'b00111) ||
                      (opcode == 5'b10100) || (opcode == 5'b10101);

  // Branch conditions look at the flags held before this instruction.
  always_comb begin
    redirect = 1'b0;
    case (opcode)
      5'b00001: redirect = o_nzp[1];
      5'b00010: redirect = o_nzp[1] | o_nzp[0];
      5'b00011: redirect = o_nzp[2] | o_nzp[0];
      5'b00100: redirect = o_nzp[2] | o_nzp[1];
      5'b01000: redirect = 1'b1;
      5'b01010: redirect = 1'b1;
      default:  redirect = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= '0;
      o_insn       <= '0;
      o_pc         <= '0;
      o_carry      <= 1'b0;
      o_insn_valid <= 1'b0;
      o_nzp        <= 3'b010;
      o_retire     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      o_illegal    <= 1'b0;
`endif
    end else begin
      o_retire <= 1'b0;
      case (state)
        S_FETCH: begin
          o_insn <= i_imem_data;
          o_pc   <= pc;
`ifdef ILLEGAL_TRAP_EN
          if (!is_legal(i_imem_data[INSN -: 5])) begin
            o_illegal <= 1'b1;
            state     <= S_HALT;
          end else begin
            o_insn_valid <= 1'b1;
            state        <= S_ISSUE;
          end
`else
          o_insn_valid <= 1'b1;
          state        <= S_ISSUE;
`endif
        end
        S_ISSUE: begin
          if (i_insn_ready) begin
            o_insn_valid <= 1'b0;
            state        <= S_WAIT_WB;
          end
        end
        S_WAIT_WB: begin
          if (i_wb_valid) begin
            if (sets_nzp) begin
              o_nzp <= {res_n, res_z, !res_n && !res_z};
            end
            if (sets_carry) begin
              o_carry <= i_wb_carry;
            end
            pc       <= redirect ? i_wb_result[IADDR:0] : pc + PC_ONE;
            o_retire <= 1'b1;
            state    <= S_FETCH;
          end
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
